exec_wb_buffer: RTL and testbench
=================================

Name: exec_wb_buffer

Overview:
- Writeback buffer that sits directly downstream of the execute stage.
- Captures each completed operation's result (value, compare bit, destination tag, optype) into an in-order FIFO.
- Presents the oldest entry to the common data bus (CDB) arbiter with a valid/ready handshake.
- Decouples execute from CDB back-pressure and supports a pipeline flush on branch mispredict.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, >= 2
TAG_WIDTH, 5, width of the ROB/destination tag carried with each result

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous squash of all buffered entries
in_valid  input  1  execute result is valid this cycle
in_ready  output  1  buffer accepts a result this cycle
in_value  input  32  result value from execute (ALU result or ld/st address)
in_comp_result  input  1  branch/compare result bit from execute
in_tag  input  TAG_WIDTH  destination tag of the operation
in_optype  input  4  optype of the operation (OPTYPE_* encoding)
out_valid  output  1  head entry valid for CDB
out_ready  input  1  CDB accepts head entry
out_value  output  32  head entry value
out_comp_result  output  1  head entry compare bit
out_tag  output  TAG_WIDTH  head entry tag
out_optype  output  4  head entry optype
count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH

Behaviour:
- Storage: DEPTH entries of {value, comp_result, tag, optype}; write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH; count register tracks occupancy.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (count < DEPTH) && !flush. No combinational dependence on out_ready, so a full buffer does not accept in the cycle it is popped.
- out_valid = (count != 0). out_* fields are driven from the entry at rd_ptr when out_valid = 1, and are forced to 0 when out_valid = 0.
- Latency: a result pushed in cycle N appears on out_* with out_valid = 1 in cycle N+1, provided the buffer was empty. There is no same-cycle bypass.
- Ordering: strict FIFO; results leave in push order.
- Push in cycle N: entry written at wr_ptr; wr_ptr+1 (wraps DEPTH-1 -> 0).
- Pop in cycle N: rd_ptr+1 (wraps); the entry content is not cleared.
- Count update: push only -> count+1; pop only -> count-1; push and pop together -> count unchanged, both pointers advance.
- Handshake rules:
  - out_* must hold stable while out_valid = 1 && out_ready = 0.
  - in_valid may be asserted while in_ready = 0; the result is not captured, and execute must hold it.
- Flush has priority over everything except rst. When flush = 1 in cycle N:
  - any pop and push in cycle N are ignored;
  - in cycle N+1: count = 0, wr_ptr = rd_ptr = 0, out_valid = 0.
- Reset (rst = 1, sampled on clk):
  - count = 0, wr_ptr = rd_ptr = 0, out_valid = 0, out_* = 0.
  - in_ready = 1 from the first cycle after rst deasserts.
  - Reset mid-operation discards all entries; storage contents need not be cleared.
- No overflow/underflow possible by construction; an assertion in the RTL checks count <= DEPTH.

Test Plan:
1. Single push: empty buffer, push {value=0x0000_1234, comp=1, tag=3, optype=OPTYPE_LOAD} with out_ready = 1 -> next cycle out_valid = 1 with identical fields; following cycle out_valid = 0, count = 0.
2. Fill/back-pressure: out_ready = 0, push values 1,2,3,4 on consecutive cycles (DEPTH = 4) -> count = 4, in_ready = 0. A fifth in_valid with value 5 is not captured. Raising out_ready drains 1,2,3,4 in order, one per cycle.
3. Simultaneous push/pop: count = 2 (heads 0xA, 0xB), push 0xC with out_ready = 1 -> count stays 2; out_value sequence 0xA, 0xB, 0xC.
4. Wrap-around: 10 push/pop cycles, values 0..9, with out_ready = 1 -> outputs 0..9 in order with no loss while pointers wrap twice.
5. Flush while full with concurrent in_valid (value 0x55) and out_ready = 1 -> next cycle count = 0, out_valid = 0. The 0x55 entry never appears, and the head entry is not counted as popped.
6. Reset mid-operation: count = 3, assert rst one cycle -> out_valid = 0, out_* = 0, count = 0. The next push appears one cycle later with the correct fields.

Source files
------------

// File: rtl/exec_wb_buffer.sv
// Writeback buffer between execute and the CDB arbiter.
// In-order FIFO of completed results with valid/ready on both sides.
module exec_wb_buffer #(
   parameter int DEPTH     = 4,
   parameter int TAG_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_value,
   input  logic                   in_comp_result,
   input  logic [TAG_WIDTH-1:0]   in_tag,
   input  logic [3:0]             in_optype,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_value,
   output logic                   out_comp_result,
   output logic [TAG_WIDTH-1:0]   out_tag,
   output logic [3:0]             out_optype,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 32 + 1 + TAG_WIDTH + 4;

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;
   logic [EW-1:0] head;

   assign in_ready  = (count_q < CW'(DEPTH)) && !flush;
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = count_q;

   assign head = out_valid ? mem_q[rd_ptr_q] : '0;
   assign {out_value, out_comp_result, out_tag, out_optype} = head;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is never cleared; validity comes only from count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_value, in_comp_result, in_tag, in_optype};
      end
   end

   a_count_bound: assert property (
      @(posedge clk) disable iff (rst) count_q <= CW'(DEPTH)
   );

endmodule

// File: tb/tb_exec_wb_buffer.sv
// Bench for exec_wb_buffer: directed scenarios plus random traffic
// checked every cycle against a queue-based reference.
module tb_exec_wb_buffer;

   localparam int DEPTH = 4;
   localparam int TW    = 5;
   localparam logic [3:0] OPTYPE_LOAD = 4'h1;

   typedef struct packed {
      logic [31:0]   v;
      logic          c;
      logic [TW-1:0] t;
      logic [3:0]    o;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready;
   logic          in_ready, out_valid;
   logic [31:0]   in_value, out_value;
   logic          in_comp_result, out_comp_result;
   logic [TW-1:0] in_tag, out_tag;
   logic [3:0]    in_optype, out_optype;
   logic [2:0]    count;

   int   n_cmp = 0;
   int   n_err = 0;
   bit   do_chk = 1'b0;
   ent_t q[$];

   always #5 clk = ~clk;

   exec_wb_buffer #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_value(in_value), .in_comp_result(in_comp_result),
      .in_tag(in_tag), .in_optype(in_optype),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_value(out_value), .out_comp_result(out_comp_result),
      .out_tag(out_tag), .out_optype(out_optype),
      .count(count)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, check outputs vs reference, advance reference.
   task automatic step(input bit r, input bit f, input bit iv,
                       input logic [31:0] v, input bit c,
                       input logic [TW-1:0] t, input logic [3:0] o,
                       input bit ordy);
      ent_t h, e;
      bit   rdy, pu, po;
      @(negedge clk);
      rst = r; flush = f; in_valid = iv; in_value = v;
      in_comp_result = c; in_tag = t; in_optype = o; out_ready = ordy;
      #1;
      h   = (q.size() != 0) ? q[0] : '0;
      rdy = (q.size() < DEPTH) && !f;
      if (do_chk) begin
         chk("count", 64'(count), 64'(q.size()));
         chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("in_ready", 64'(in_ready), 64'(rdy));
         chk("out_value", 64'(out_value), 64'(h.v));
         chk("out_comp", 64'(out_comp_result), 64'(h.c));
         chk("out_tag", 64'(out_tag), 64'(h.t));
         chk("out_optype", 64'(out_optype), 64'(h.o));
      end
      if (r || f) begin
         q.delete();
      end else begin
         po = (q.size() != 0) && ordy;
         pu = iv && rdy;
         e  = '{v: v, c: c, t: t, o: o};
         if (po) void'(q.pop_front());
         if (pu) q.push_back(e);
      end
   endtask

   task automatic idle(input bit ordy);
      step(0, 0, 0, 32'h0, 0, '0, 4'h0, ordy);
   endtask

   task automatic push(input logic [31:0] v, input bit ordy);
      step(0, 0, 1, v, v[0], TW'(v), v[3:0], ordy);
   endtask

   initial begin
      step(1, 0, 0, 0, 0, '0, 0, 0);
      do_chk = 1'b1;
      step(1, 0, 0, 0, 0, '0, 0, 0);
      idle(0);

      // single push, visible next cycle, gone the cycle after
      step(0, 0, 1, 32'h1234, 1, 5'd3, OPTYPE_LOAD, 1);
      idle(1);
      chk("t1_value", 64'(out_value), 64'h1234);
      chk("t1_tag", 64'(out_tag), 64'd3);
      idle(1);
      chk("t1_empty", 64'(out_valid), 64'd0);

      // fill, refuse fifth, drain in order
      for (int i = 1; i <= 5; i++) push(32'(i), 0);
      chk("t2_full", 64'(count), 64'd4);
      for (int i = 0; i < 5; i++) idle(1);

      // simultaneous push/pop
      push(32'hA, 0);
      push(32'hB, 0);
      push(32'hC, 1);
      chk("t3_count", 64'(count), 64'd2);
      idle(1); idle(1); idle(1);

      // wrap-around
      for (int i = 0; i < 10; i++) push(32'(i), 1);
      idle(1); idle(1);

      // flush while full with concurrent push and pop
      for (int i = 0; i < 4; i++) push(32'h10 + 32'(i), 0);
      step(0, 1, 1, 32'h55, 0, '0, 0, 1);
      idle(1);
      chk("t5_flushed", 64'(count), 64'd0);
      idle(1);

      // reset mid-operation
      for (int i = 0; i < 3; i++) push(32'h20 + 32'(i), 0);
      step(1, 0, 0, 0, 0, '0, 0, 0);
      push(32'h77, 0);
      idle(1);
      chk("t6_value", 64'(out_value), 64'h77);
      idle(1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(99) == 0), ($urandom_range(49) == 0),
              ($urandom_range(9) < 6), $urandom, 1'($urandom),
              TW'($urandom), 4'($urandom), ($urandom_range(9) < 5));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
